// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration sequencer.
package cgra_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned NOP_ADDR   = 0;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cgra_cfg_timer.sv
// Loadable down-counter with zero flag; stops at zero until reloaded.
module cgra_cfg_timer
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cgra_config_sequencer.sv
// Streams bitstream beats into the CGRA config port, waits a settle window,
// then opens a bounded run window for the pad datapath.
module cgra_config_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned RUN_CYCLES     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start,
  input  logic              abort,
  input  logic              bs_valid,
  output logic              bs_ready,
  input  logic [ADDR_W-1:0] bs_addr,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_last,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              config_done,
  output logic              run_en,
  output logic              run_done,
  output logic [CNT_W-1:0]  word_count,
  output logic              err,
  output logic              busy
);

  localparam int unsigned TMR_W = cnt_width(max3(SETTLE_CYCLES, RUN_CYCLES, TIMEOUT_CYCLES));

  // Timer reaches zero on the last cycle of each window, hence the minus-one reloads.
  localparam logic [TMR_W-1:0] LOAD_RELOAD =
      TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RUN_RELOAD =
      TMR_W'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_RELOAD = TMR_W'(SETTLE_CYCLES);

  state_e            r_state;
  logic [ADDR_W-1:0] r_cfg_addr;
  logic [DATA_W-1:0] r_cfg_data;
  logic              r_cfg_done;
  logic              r_run_en;
  logic              r_run_done;
  logic [CNT_W-1:0]  r_word_count;
  logic              r_err;

  logic              w_accept;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_zero;

  assign bs_ready = (r_state == StLoad) && !abort && !reset_in;
  assign w_accept = bs_valid && bs_ready;
  assign busy     = (r_state == StLoad) || (r_state == StSettle) || (r_state == StRun);

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LOAD_RELOAD;
        end
      end
      StLoad: begin
        if (w_accept) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = bs_last ? SETTLE_RELOAD : LOAD_RELOAD;
        end
      end
      StSettle: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = RUN_RELOAD;
        end
      end
      default: ;
    endcase
  end

  cgra_cfg_timer #(
    .W(TMR_W)
  ) u_timer (
    .i_clk      (clk_in),
    .i_rst      (reset_in),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state      <= StIdle;
      r_cfg_addr   <= '0;
      r_cfg_data   <= '0;
      r_cfg_done   <= 1'b0;
      r_run_en     <= 1'b0;
      r_run_done   <= 1'b0;
      r_word_count <= '0;
      r_err        <= 1'b0;
    end else if (abort) begin
      // word_count and err survive an abort so the host can inspect them.
      r_state    <= StIdle;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_cfg_done <= 1'b0;
      r_run_en   <= 1'b0;
      r_run_done <= 1'b0;
    end else begin
      r_cfg_addr <= ADDR_W'(NOP_ADDR);
      r_run_done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state      <= StLoad;
            r_word_count <= '0;
            r_err        <= 1'b0;
            r_cfg_done   <= 1'b0;
          end
        end
        StLoad: begin
          if (w_accept) begin
            r_cfg_addr <= bs_addr;
            r_cfg_data <= bs_data;
            if (bs_addr != ADDR_W'(NOP_ADDR) && r_word_count != '1) begin
              r_word_count <= r_word_count + CNT_W'(1);
            end
            if (bs_last) begin
              r_state <= StSettle;
            end
          end else if (TIMEOUT_CYCLES != 0 && w_tmr_zero) begin
            r_err      <= 1'b1;
            r_state    <= StIdle;
            r_cfg_data <= '0;
          end
        end
        StSettle: begin
          if (w_tmr_zero) begin
            r_state    <= StRun;
            r_cfg_done <= 1'b1;
            r_run_en   <= 1'b1;
          end
        end
        StRun: begin
          if (RUN_CYCLES != 0 && w_tmr_zero) begin
            r_state    <= StDone;
            r_run_en   <= 1'b0;
            r_run_done <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign config_addr_out = r_cfg_addr;
  assign config_data_out = r_cfg_data;
  assign config_done     = r_cfg_done;
  assign run_en          = r_run_en;
  assign run_done        = r_run_done;
  assign word_count      = r_word_count;
  assign err             = r_err;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Randomized bench for cgra_config_sequencer against a timestamp-based reference model.
module tb_cgra_config_sequencer;

  localparam int unsigned S = 4;
  localparam int unsigned R = 1024;
  localparam int unsigned T = 256;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        bs_valid = 1'b0;
  logic        bs_last = 1'b0;
  logic [31:0] bs_addr = '0;
  logic [31:0] bs_data = '0;

  logic        bs_ready, config_done, run_en, run_done, err, busy;
  logic [31:0] config_addr_out, config_data_out;
  logic [15:0] word_count;

  logic        sat_bs_ready, sat_config_done, sat_run_en, sat_run_done, sat_err, sat_busy;
  logic [31:0] sat_addr, sat_data;
  logic [1:0]  sat_word_count;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  // Reference model: timestamps of sequence milestones, in edge numbers.
  int unsigned cyc = 0;
  bit          m_active = 0;
  bit          m_loading = 0;
  bit          m_err = 0;
  int unsigned m_wc = 0;
  int unsigned m_last_act = 0;
  int unsigned m_done_at = 0;
  int unsigned m_run_end = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;

  always #5 clk_in = ~clk_in;

  cgra_config_sequencer dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .start           (start),
    .abort           (abort),
    .bs_valid        (bs_valid),
    .bs_ready        (bs_ready),
    .bs_addr         (bs_addr),
    .bs_data         (bs_data),
    .bs_last         (bs_last),
    .config_addr_out (config_addr_out),
    .config_data_out (config_data_out),
    .config_done     (config_done),
    .run_en          (run_en),
    .run_done        (run_done),
    .word_count      (word_count),
    .err             (err),
    .busy            (busy)
  );

  cgra_config_sequencer #(
    .CNT_W(2)
  ) dut_sat (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .start           (start),
    .abort           (abort),
    .bs_valid        (bs_valid),
    .bs_ready        (sat_bs_ready),
    .bs_addr         (bs_addr),
    .bs_data         (bs_data),
    .bs_last         (bs_last),
    .config_addr_out (sat_addr),
    .config_data_out (sat_data),
    .config_done     (sat_config_done),
    .run_en          (sat_run_en),
    .run_done        (sat_run_done),
    .word_count      (sat_word_count),
    .err             (sat_err),
    .busy            (sat_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ab, input bit st, input bit v,
                            input logic [31:0] a, input logic [31:0] d, input bit l);
    cyc++;
    m_addr = '0;
    if (rst) begin
      m_active = 0; m_loading = 0; m_wc = 0; m_err = 0; m_data = '0;
    end else if (ab) begin
      m_active = 0; m_loading = 0; m_data = '0;
    end else if (st && (!m_active || (!m_loading && cyc > m_run_end))) begin
      m_active = 1; m_loading = 1; m_last_act = cyc; m_wc = 0; m_err = 0;
    end else if (m_active && m_loading) begin
      if (v) begin
        m_addr = a;
        m_data = d;
        if (a != 0) m_wc++;
        m_last_act = cyc;
        if (l) begin
          m_loading = 0;
          m_done_at = cyc + S + 1;
          m_run_end = m_done_at + R;
        end
      end else if (cyc - m_last_act == T) begin
        m_err = 1; m_active = 0; m_loading = 0; m_data = '0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit ab, input bit st, input bit v,
                      input logic [31:0] a, input logic [31:0] d, input bit l);
    bit exp_ready, in_post, exp_done;
    @(negedge clk_in);
    reset_in = rst; abort = ab; start = st; bs_valid = v;
    bs_addr = a; bs_data = d; bs_last = l;
    #1;
    exp_ready = m_active && m_loading && !ab && !rst;
    check_eq("bs_ready", bs_ready, exp_ready);
    check_eq("sat_bs_ready", sat_bs_ready, exp_ready);
    model_edge(rst, ab, st, v, a, d, l);
    in_post  = m_active && !m_loading;
    exp_done = in_post && cyc >= m_done_at;
    @(posedge clk_in);
    #1;
    check_eq("config_addr_out", config_addr_out, m_addr);
    check_eq("config_data_out", config_data_out, m_data);
    check_eq("config_done", config_done, exp_done);
    check_eq("run_en", run_en, exp_done && cyc < m_run_end);
    check_eq("run_done", run_done, in_post && cyc == m_run_end);
    check_eq("word_count", word_count, (m_wc > 65535) ? 65535 : m_wc);
    check_eq("sat_word_count", sat_word_count, (m_wc > 3) ? 3 : m_wc);
    check_eq("err", err, m_err);
    check_eq("busy", busy, m_active && (m_loading || cyc < m_run_end));
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input bit l);
    step(0, 0, 0, 1, a, d, l);
  endtask

  task automatic go();
    step(0, 0, 1, 0, '0, '0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, '0, '0, 0);
    step(1, 0, 0, 0, '0, '0, 0);
    idle(2);

    // Normal three-beat load through a full run window.
    go();
    beat(32'h0001_0001, 32'hDEAD_BEEF, 0);
    beat(32'h0002_0002, 32'h0000_0001, 0);
    beat(32'h0003_0003, 32'h0000_0002, 1);
    idle(S + 1 + R + 5);

    // Gapped valid, then abort partway into the run window.
    go();
    beat(32'h0000_0010, 32'h1111_1111, 0);
    idle(2);
    beat(32'h0000_0020, 32'h2222_2222, 1);
    idle(S + 20);
    step(0, 1, 0, 0, '0, '0, 0);
    idle(2);

    // Timeout, then a fresh start clears err.
    go();
    idle(T + 4);
    go();
    idle(2);
    step(0, 1, 0, 0, '0, '0, 0);

    // Abort alongside a valid third beat.
    go();
    beat(32'h0000_0100, 32'hAAAA_0001, 0);
    beat(32'h0000_0200, 32'hAAAA_0002, 0);
    step(0, 1, 0, 1, 32'h0000_0300, 32'hAAAA_0003, 0);
    idle(2);

    // No-op beats plus counter saturation on the narrow instance.
    go();
    for (int i = 0; i < 7; i++) beat((i % 3 == 1) ? 32'h0 : 32'h40 + i, $urandom, i == 6);
    idle(10);
    step(0, 1, 1, 0, '0, '0, 0);

    // Reset during RUN with start held alongside it.
    go();
    beat(32'h0000_0500, 32'h5555_5555, 1);
    idle(S + 10);
    step(1, 0, 1, 0, '0, '0, 0);
    idle(3);

    for (int it = 0; it < 20; it++) begin
      int unsigned n;
      int unsigned pv;
      go();
      n  = $urandom_range(1, 40);
      pv = ($urandom_range(0, 4) == 0) ? 1 : 6;
      for (int j = 0; j < n; j++) begin
        step(0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < pv), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
             $urandom, ($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 2) == 0) idle(1100);
      else idle($urandom_range(0, 40));
      if ($urandom_range(0, 4) == 0) step(1, 0, 0, 0, '0, '0, 0);
      else step(0, 1, 0, 0, '0, '0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cgra_config_sequencer.md
Name: cgra_config_sequencer

Overview:
- Sequences CGRA bring-up. Streams (addr, data) bitstream words into the array's config_addr_in/config_data_in pair.
- Waits a settle window, then opens a bounded run window for the pad datapath.
- Sits between the bitstream source (file reader in sim, DMA/host FIFO in silicon) and `top`, replacing ad-hoc bench sequencing.

Parameters:
- ADDR_W, 32, config address width
- DATA_W, 32, config data width
- SETTLE_CYCLES, 4, idle cycles (addr=0) after last config write before config_done
- RUN_CYCLES, 1024, run-window length; 0 = run until abort
- TIMEOUT_CYCLES, 256, max cycles in LOAD without an accepted beat before error
- CNT_W, 16, width of word counter

Ports:
- clk_in  in  1  clock
- reset_in  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a configuration sequence
- abort  in  1  return to IDLE next cycle from any state
- bs_valid  in  1  bitstream beat valid
- bs_ready  out  1  sequencer accepts beat
- bs_addr  in  ADDR_W  config address of beat
- bs_data  in  DATA_W  config data of beat
- bs_last  in  1  final beat of bitstream
- config_addr_out  out  ADDR_W  to top.config_addr_in; 0 = no-op
- config_data_out  out  DATA_W  to top.config_data_in
- config_done  out  1  high from end of SETTLE until next start/abort/reset
- run_en  out  1  high during RUN; gates pad stimulus/capture
- run_done  out  1  one-cycle pulse on RUN->DONE
- word_count  out  CNT_W  accepted non-zero-address beats, saturating
- err  out  1  sticky timeout flag, cleared by start or reset
- busy  out  1  state is LOAD, SETTLE or RUN

Behaviour:
- Reset (reset_in high at a clk_in edge): state IDLE. All outputs 0: config_addr_out, config_data_out, word_count, err, config_done, run_en, run_done, bs_ready.
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE/DONE + start -> LOAD. On that transition: clear word_count, err and config_done. start is ignored in LOAD/SETTLE/RUN.
- LOAD:
  - bs_ready=1 combinationally.
  - Beat accepted when bs_valid&bs_ready. The registered config_addr_out/config_data_out take bs_addr/bs_data on the next edge (latency 1).
  - In any cycle after which no beat is accepted, config_addr_out=0 and config_data_out is held. This gives a one-cycle write strobe per beat; back-to-back beats give back-to-back writes.
  - Beats with bs_addr==0 are forwarded (harmless no-op) but not counted.
  - Accepted beat with bs_last -> SETTLE.
- LOAD timeout counter:
  - Resets on every accepted beat.
  - Reaching TIMEOUT_CYCLES consecutive cycles with no beat: err=1, -> IDLE, outputs zeroed.
- SETTLE:
  - bs_ready=0, config_addr_out=0.
  - Counts SETTLE_CYCLES cycles, then -> RUN with config_done=1 in the same edge.
  - SETTLE_CYCLES=0 -> RUN directly on the edge after the last write.
- RUN:
  - run_en=1, config_done=1.
  - Counts RUN_CYCLES cycles, then -> DONE with run_done=1 for exactly one cycle and run_en=0.
  - RUN_CYCLES=0: stay in RUN until abort.
- DONE: config_done stays 1; start re-enters LOAD (reconfiguration).
- abort:
  - Highest priority after reset. Any state -> IDLE next edge.
  - Zeroes config_addr_out, run_en, config_done and bs_ready.
  - Preserves word_count and err.
  - A beat presented in the abort cycle is not accepted (bs_ready=0 while abort=1).
- Simultaneous start & abort in IDLE: abort wins, stay IDLE.
- word_count saturates at 2^CNT_W-1.
- All counters are internal, width ceil(log2(max param+1)).

Decomposition:
- Package cgra_cfg_pkg: state enum, ADDR_W/DATA_W defaults, NOP_ADDR constant (0).
- One natural sub-module: cgra_cfg_timer. Loadable down-counter with zero flag, shared for SETTLE, RUN and LOAD timeout (three instances, or one reloaded per state).

Test Plan:
- Normal load: start, then 3 beats (0x00010001/0xDEADBEEF, 0x00020002/0x1, 0x00030003/0x2 with last), bs_valid continuous. Expect:
  - three consecutive config_addr_out strobes, each one cycle after acceptance
  - word_count=3
  - config_done high 4 cycles after the last strobe
  - run_en for 1024 cycles, then a single run_done pulse.
- Back-pressure gaps: valid toggles 1,0,0,1 with 2 beats. Expect:
  - config_addr_out=0 in the gap cycles
  - exactly 2 strobes, no duplicates
  - err=0.
- Timeout: start, then no bs_valid for 256 cycles. Expect err=1, state IDLE, busy=0, bs_ready=0; next start clears err.
- Abort mid-LOAD after 2 beats (abort asserted alongside a valid 3rd beat). Expect:
  - 3rd beat not accepted (bs_ready=0)
  - next cycle all outputs zero except word_count=2.
- No-op and saturation: beats with addr 0 are forwarded but word_count is unchanged. With CNT_W=2, 5 non-zero beats give word_count=3.
- Reset during RUN: reset_in=1 for one cycle. Next cycle run_en=0, config_done=0, word_count=0, state IDLE; a start during reset is ignored.
